// File: rtl/mux_gate_scheduler_if.sv
// rtl/mux_gate_scheduler_if.sv - request/operand/result bundle between two requesters and the XOR/XNOR scheduler
interface mux_gate_scheduler_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             op0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             op1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] y;

    modport master (
        output req, a0, b0, op0, a1, b1, op1,
        input  gnt, busy, done, done_id, y
    );

    modport slave (
        input  req, a0, b0, op0, a1, b1, op1,
        output gnt, busy, done, done_id, y
    );
endinterface

// File: rtl/mux_gate_scheduler.sv
// rtl/mux_gate_scheduler.sv - two-requester serial XOR/XNOR scheduler over one mux-built bit slice
// Define MUXSCHED_RR_EN for round-robin arbitration on simultaneous requests; default is fixed priority to requester 0.
module mux_gate_scheduler #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_gate_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic [WIDTH-1:0] shift_q;
    logic [IDX_W-1:0] idx;
    logic [1:0]       gnt_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;
    logic [WIDTH-1:0] y_q;

    logic             win;
    logic             a_bit;
    logic             b_bit;
    logic             b_n;
    logic             slice_bit;
    logic [WIDTH-1:0] next_shift;

`ifdef MUXSCHED_RR_EN
    logic prefer;
`endif

    // req[0] low means only requester 1 can be asking when this is used
    always_comb begin
        win = ~bus.req[0];
`ifdef MUXSCHED_RR_EN
        if (bus.req == 2'b11) begin
            win = prefer;
        end
`endif
    end

    assign a_bit = a_q[idx];
    assign b_bit = b_q[idx];
    assign b_n   = ~b_bit;

    // Shared gate slice: a 4:1 mux on {op, a} choosing b or ~b gives XOR/XNOR
    always_comb begin
        case ({op_q, a_bit})
            2'b00:   slice_bit = b_bit;
            2'b01:   slice_bit = b_n;
            2'b10:   slice_bit = b_n;
            default: slice_bit = b_bit;
        endcase
    end

    assign next_shift = {slice_bit, shift_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            shift_q   <= '0;
            idx       <= '0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            y_q       <= '0;
`ifdef MUXSCHED_RR_EN
            prefer    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.req != 2'b00) begin
                        a_q       <= win ? bus.a1 : bus.a0;
                        b_q       <= win ? bus.b1 : bus.b0;
                        op_q      <= win ? bus.op1 : bus.op0;
                        gnt_q     <= win ? 2'b10 : 2'b01;
                        done_id_q <= win;
                        idx       <= '0;
                        busy_q    <= 1'b1;
                        state     <= RUN;
`ifdef MUXSCHED_RR_EN
                        prefer    <= ~win;
`endif
                    end
                end
                RUN: begin
                    shift_q <= next_shift;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        y_q    <= next_shift;
                        gnt_q  <= 2'b00;
                        done_q <= 1'b1;
                        idx    <= '0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    gnt_q  <= 2'b00;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.y       = y_q;
endmodule

// File: tb/tb_mux_gate_scheduler.sv
// tb/tb_mux_gate_scheduler.sv - vector table, corner sequences and randomized word-level model check of mux_gate_scheduler
module tb_mux_gate_scheduler;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    mux_gate_scheduler_if #(.WIDTH(W)) bus ();

    mux_gate_scheduler #(.WIDTH(W), .IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level model: position within an operation, counted in edges since grant
    int         m_cnt;
    logic [1:0] m_gnt;
    logic [W-1:0] m_y;
    logic [W-1:0] m_res;
    logic       m_id;
    logic       m_last;

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic         op0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic         op1;
        logic [W-1:0] exp_y;
        logic         exp_id;
    } vec_t;

    vec_t vec[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_gnt  = 2'b00;
        m_y    = '0;
        m_res  = '0;
        m_id   = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic check_outputs();
        check("gnt", {30'd0, bus.gnt}, {30'd0, m_gnt});
        check("busy", {31'd0, bus.busy}, {31'd0, m_cnt != 0});
        check("done", {31'd0, bus.done}, {31'd0, m_cnt == W + 1});
        check("done_id", {31'd0, bus.done_id}, {31'd0, m_id});
        check("y", {24'd0, bus.y}, {24'd0, m_y});
    endtask

    // One clock: inputs as seen at the edge drive the model, then every output is compared
    task automatic cycle();
        logic [1:0]   r;
        logic [W-1:0] ca0, cb0, ca1, cb1;
        logic         co0, co1, w;
        r = bus.req; ca0 = bus.a0; cb0 = bus.b0; co0 = bus.op0;
        ca1 = bus.a1; cb1 = bus.b1; co1 = bus.op1;
        @(posedge clk);
        #1;
        if (m_cnt == 0) begin
            if (r != 2'b00) begin
                if (r == 2'b11) begin
`ifdef MUXSCHED_RR_EN
                    w = ~m_last;
`else
                    w = 1'b0;
`endif
                end else begin
                    w = r[1];
                end
                if (w) m_res = co1 ? ~(ca1 ^ cb1) : (ca1 ^ cb1);
                else   m_res = co0 ? ~(ca0 ^ cb0) : (ca0 ^ cb0);
                m_id   = w;
                m_last = w;
                m_gnt  = w ? 2'b10 : 2'b01;
                m_cnt  = 1;
            end
        end else if (m_cnt == W) begin
            m_y   = m_res;
            m_gnt = 2'b00;
            m_cnt = W + 1;
        end else if (m_cnt == W + 1) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        bus.req = v.req; bus.a0 = v.a0; bus.b0 = v.b0; bus.op0 = v.op0;
        bus.a1 = v.a1; bus.b1 = v.b1; bus.op1 = v.op1;
    endtask

    // After a grant edge: run until done, return edges from grant to done
    task automatic wait_done(output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle();
            lat++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    int     lat;
    logic   seen;
    logic   ids[3];
    logic [W-1:0] ys[3];
    int     nd;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.req = 2'b00; bus.a0 = '0; bus.b0 = '0; bus.op0 = 1'b0;
        bus.a1 = '0; bus.b1 = '0; bus.op1 = 1'b0;
        model_reset();

        vec[0] = '{2'b01, 8'hA5, 8'h3C, 1'b0, 8'h11, 8'h22, 1'b1, 8'h99, 1'b0};
        vec[1] = '{2'b10, 8'h77, 8'h77, 1'b1, 8'hA5, 8'h3C, 1'b1, 8'h66, 1'b1};
        vec[2] = '{2'b01, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vec[3] = '{2'b10, 8'h5A, 8'h5A, 1'b0, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b1};
        vec[4] = '{2'b01, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b1, 8'h26, 1'b0};
        vec[5] = '{2'b10, 8'h00, 8'h00, 1'b0, 8'h80, 8'h01, 1'b1, 8'h7E, 1'b1};

        #23;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            drive(vec[v]);
            cycle();
            bus.req = 2'b00;
            wait_done(lat, seen);
            check("tbl_done_seen", {31'd0, seen}, 32'd1);
            check("tbl_latency", lat, W);
            check("tbl_y", {24'd0, bus.y}, {24'd0, vec[v].exp_y});
            check("tbl_id", {31'd0, bus.done_id}, {31'd0, vec[v].exp_id});
            cycle();
        end

        // Sustained contention from reset
        do_reset();
        bus.a0 = 8'hFF; bus.b0 = 8'h0F; bus.op0 = 1'b0;
        bus.a1 = 8'h00; bus.b1 = 8'h00; bus.op1 = 1'b0;
        bus.req = 2'b11;
        nd = 0;
        for (int c = 0; c < 40 && nd < 3; c++) begin
            cycle();
            if (bus.done) begin
                ids[nd] = bus.done_id;
                ys[nd]  = bus.y;
                nd++;
            end
        end
        bus.req = 2'b00;
        check("contend_count", nd, 3);
`ifdef MUXSCHED_RR_EN
        check("contend_id0", {31'd0, ids[0]}, 32'd0);
        check("contend_id1", {31'd0, ids[1]}, 32'd1);
        check("contend_id2", {31'd0, ids[2]}, 32'd0);
        check("contend_y1", {24'd0, ys[1]}, 32'h00);
`else
        check("contend_id0", {31'd0, ids[0]}, 32'd0);
        check("contend_id1", {31'd0, ids[1]}, 32'd0);
        check("contend_id2", {31'd0, ids[2]}, 32'd0);
        check("contend_y1", {24'd0, ys[1]}, 32'hF0);
`endif
        check("contend_y0", {24'd0, ys[0]}, 32'hF0);
        check("contend_y2", {24'd0, ys[2]}, 32'hF0);
        cycle();
        cycle();

        // Operand change and req drop mid-RUN
        bus.a0 = 8'h0F; bus.b0 = 8'hF0; bus.op0 = 1'b0; bus.req = 2'b01;
        cycle();
        cycle();
        cycle();
        bus.a0 = 8'h00; bus.b0 = 8'h00; bus.op0 = 1'b1; bus.req = 2'b00;
        lat = 2;
        begin
            int l2;
            wait_done(l2, seen);
            lat = lat + l2;
        end
        check("hold_done_seen", {31'd0, seen}, 32'd1);
        check("hold_latency", lat, W);
        check("hold_y", {24'd0, bus.y}, 32'hFF);
        cycle();

        // Asynchronous reset mid-RUN, after a requester-1 result is showing
        bus.a1 = 8'hFF; bus.b1 = 8'h00; bus.op1 = 1'b0; bus.req = 2'b10;
        cycle();
        bus.req = 2'b00;
        wait_done(lat, seen);
        cycle();
        bus.a0 = 8'hA5; bus.b0 = 8'h3C; bus.op0 = 1'b0; bus.req = 2'b01;
        cycle();
        for (int c = 0; c < 4; c++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("areset_gnt", {30'd0, bus.gnt}, 32'd0);
        check("areset_busy", {31'd0, bus.busy}, 32'd0);
        check("areset_done", {31'd0, bus.done}, 32'd0);
        check("areset_id", {31'd0, bus.done_id}, 32'd0);
        check("areset_y", {24'd0, bus.y}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        bus.req = 2'b00;
        wait_done(lat, seen);
        check("restart_done_seen", {31'd0, seen}, 32'd1);
        check("restart_latency", lat, W);
        check("restart_y", {24'd0, bus.y}, 32'h99);
        cycle();

        // Idle hold
        bus.req = 2'b00;
        for (int c = 0; c < 20; c++) cycle();
        check("idle_y_hold", {24'd0, bus.y}, 32'h99);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            bus.req = 2'($urandom_range(0, 3));
            bus.a0 = 8'($urandom); bus.b0 = 8'($urandom); bus.op0 = 1'($urandom);
            bus.a1 = 8'($urandom); bus.b1 = 8'($urandom); bus.op1 = 1'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
